// File: rtl/twotoone_pkg.sv
// rtl/twotoone_pkg.sv - shared constants and types for the two-source arbiter
package twotoone_pkg;

   localparam logic SRC_IN1 = 1'b0;
   localparam logic SRC_IN2 = 1'b1;

   localparam int ARB_CNT_W = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_t;

   // Saturating increment used by the grant counters
   function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/twotoone.sv
// rtl/twotoone.sv - WIDTH-wide 2:1 mux, sel picks in2 when it names SRC_IN2
module twotoone
   import twotoone_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   assign out = (sel == SRC_IN2) ? in2 : in1;

endmodule

// File: rtl/twotoone_arb.sv
// rtl/twotoone_arb.sv - two-source round-robin arbiter with a one-entry output register
// Optional grant counters cnt1/cnt2 are built when TWOTOONE_ARB_CNT_EN is defined.
module twotoone_arb
   import twotoone_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   input  logic             in2_valid,
   input  logic [WIDTH-1:0] in2_data,
   output logic             in2_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel
`ifdef TWOTOONE_ARB_CNT_EN
  ,output logic [ARB_CNT_W-1:0] cnt1,
   output logic [ARB_CNT_W-1:0] cnt2
`endif
);

   arb_state_t       state_q, state_d;
   logic             prio_q;
   logic [WIDTH-1:0] data_q;
   logic             sel_q;
   logic             load_en;
   logic             any_valid;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] mux_data;

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign sel       = sel_q;

   // Output slot can take a word when empty or when it is being popped now
   assign load_en   = !out_valid || out_ready;
   assign any_valid = in1_valid || in2_valid;

   always_comb begin
      grant = SRC_IN1;
      if (in1_valid && in2_valid)
         grant = prio_q;
      else if (in2_valid)
         grant = SRC_IN2;
   end

   assign accept    = !rst && load_en && any_valid;
   assign in1_ready = accept && (grant == SRC_IN1);
   assign in2_ready = accept && (grant == SRC_IN2);

   twotoone #(.WIDTH(WIDTH)) u_mux (
      .in1 (in1_data),
      .in2 (in2_data),
      .sel (grant),
      .out (mux_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept)
               state_d = ST_FULL;
         end
         ST_FULL: begin
            if (out_ready && !accept)
               state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         prio_q  <= SRC_IN1;
         data_q  <= '0;
         sel_q   <= SRC_IN1;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q <= mux_data;
            sel_q  <= grant;
            prio_q <= ~grant;
         end
      end
   end

`ifdef TWOTOONE_ARB_CNT_EN
   logic [ARB_CNT_W-1:0] cnt1_q, cnt2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         if (in1_ready)
            cnt1_q <= sat_inc(cnt1_q);
         if (in2_ready)
            cnt2_q <= sat_inc(cnt2_q);
      end
   end

   assign cnt1 = cnt1_q;
   assign cnt2 = cnt2_q;
`endif

endmodule
